// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with enable prescaler, runtime limit, parallel load,
// and wrap or saturate behaviour at the limits.
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             wrapped,
  output logic             at_limit
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_reg, pre_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrapped_reg, wrapped_next;
  logic             step;

  always_comb begin
    pre_next     = pre_reg;
    count_next   = count_reg;
    wrapped_next = 1'b0;
    step         = 1'b0;

    if (load) begin
      count_next = load_val;
      pre_next   = '0;
    end else if (en) begin
      if (pre_reg == PRE_LAST) begin
        pre_next = '0;
        step     = 1'b1;
      end else begin
        pre_next = pre_reg + PW'(1);
      end
    end

    // Limits are tested before the +/-1, so a loaded value above max_val
    // is treated as already at the limit.
    if (step) begin
      if (up) begin
        if (count_reg < max_val) begin
          count_next = count_reg + WIDTH'(1);
        end else if (SATURATE != 0) begin
          count_next = max_val;
        end else begin
          count_next   = '0;
          wrapped_next = 1'b1;
        end
      end else begin
        if (count_reg != '0) begin
          count_next = count_reg - WIDTH'(1);
        end else if (SATURATE == 0) begin
          count_next   = max_val;
          wrapped_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_reg     <= '0;
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
    end else begin
      pre_reg     <= pre_next;
      count_reg   <= count_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign count    = count_reg;
  assign wrapped  = wrapped_reg;
  assign at_limit = up ? (count_reg >= max_val) : (count_reg == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three configurations driven with shared
// stimulus, table-driven vectors checked through an expected-value queue.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [7:0] load_val, max_val;

  logic [2:0] count_a;
  logic [7:0] count_b, count_c;
  logic       wrapped_a, wrapped_b, wrapped_c;
  logic       at_limit_a, at_limit_b, at_limit_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: 3-bit wrap, B: 8-bit prescale-4 wrap, C: 8-bit saturating
  updown_mod_counter #(.WIDTH(3), .PRESCALE(1), .SATURATE(0)) u_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[2:0]), .max_val(max_val[2:0]),
    .count(count_a), .wrapped(wrapped_a), .at_limit(at_limit_a));

  updown_mod_counter #(.WIDTH(8), .PRESCALE(4), .SATURATE(0)) u_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val),
    .count(count_b), .wrapped(wrapped_b), .at_limit(at_limit_b));

  updown_mod_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(1)) u_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val),
    .count(count_c), .wrapped(wrapped_c), .at_limit(at_limit_c));

  typedef struct {
    string      name;
    logic       rst, en, up, load;
    logic [7:0] lv, mv;
    int         dut;   // 0=A 1=B 2=C 3=all
    logic [7:0] cnt;
    logic       wr, al;
  } vec_t;

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] cnt;
    logic       wr, al;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic add(input string name, input logic r, e, u, l,
                     input logic [7:0] lv, mv, input int dut,
                     input logic [7:0] cnt, input logic wr, al);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.up = u; v.load = l;
    v.lv = lv; v.mv = mv; v.dut = dut; v.cnt = cnt; v.wr = wr; v.al = al;
    vecs.push_back(v);
  endtask

  task automatic sample(input int d, output logic [7:0] c, output logic w, a);
    case (d)
      0:       begin c = {5'd0, count_a}; w = wrapped_a; a = at_limit_a; end
      1:       begin c = count_b; w = wrapped_b; a = at_limit_b; end
      default: begin c = count_c; w = wrapped_c; a = at_limit_c; end
    endcase
  endtask

  task automatic check_one(input string name, input int d,
                           input logic [7:0] ec, input logic ew, ea);
    logic [7:0] c;
    logic       w, a;
    sample(d, c, w, a);
    checks++;
    if (c !== ec || w !== ew || a !== ea) begin
      errors++;
      $display("FAIL %s dut%0d: got count=%0d wrapped=%0b at_limit=%0b, want count=%0d wrapped=%0b at_limit=%0b",
               name, d, c, w, a, ec, ew, ea);
    end else begin
      $display("ok   %s dut%0d: count=%0d wrapped=%0b at_limit=%0b", name, d, c, w, a);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; max_val = 8'd7;

    // Reset overrides a simultaneous load.
    add("rst",     0,1,1,1, 8'd5, 8'd7, 3, 8'd0, 0, 0);
    // 3-bit free-running up count through the wrap.
    for (int k = 1; k <= 7; k++)
      add("up3",   1,1,1,0, 8'd0, 8'd7, 0, 8'(k), 0, (k == 7));
    add("wrap3",   1,1,1,0, 8'd0, 8'd7, 0, 8'd0, 1, 0);
    add("post3",   1,1,1,0, 8'd0, 8'd7, 0, 8'd1, 0, 0);
    // Prescaler of 4 with an en=0 gap.
    add("ldB",     1,1,1,1, 8'd0, 8'd9, 1, 8'd0, 0, 0);
    add("pre1",    1,1,1,0, 8'd0, 8'd9, 1, 8'd0, 0, 0);
    add("pre2",    1,1,1,0, 8'd0, 8'd9, 1, 8'd0, 0, 0);
    add("en0",     1,0,1,0, 8'd0, 8'd9, 1, 8'd0, 0, 0);
    add("pre3",    1,1,1,0, 8'd0, 8'd9, 1, 8'd0, 0, 0);
    add("stepB",   1,1,1,0, 8'd0, 8'd9, 1, 8'd1, 0, 0);
    for (int k = 0; k < 3; k++)
      add("preB",  1,1,1,0, 8'd0, 8'd9, 1, 8'd1, 0, 0);
    add("stepB2",  1,1,1,0, 8'd0, 8'd9, 1, 8'd2, 0, 0);
    // Prescaled up wrap on B.
    add("ldB9",    1,1,1,1, 8'd9, 8'd9, 1, 8'd9, 0, 1);
    for (int k = 0; k < 3; k++)
      add("preB9", 1,1,1,0, 8'd0, 8'd9, 1, 8'd9, 0, 1);
    add("wrapB",   1,1,1,0, 8'd0, 8'd9, 1, 8'd0, 1, 0);
    add("postB",   1,1,1,0, 8'd0, 8'd9, 1, 8'd0, 0, 0);
    // Down wrap on A with max 5.
    add("ldDn",    1,1,0,1, 8'd1, 8'd5, 0, 8'd1, 0, 0);
    add("dn0",     1,1,0,0, 8'd0, 8'd5, 0, 8'd0, 0, 1);
    add("dnWrap",  1,1,0,0, 8'd0, 8'd5, 0, 8'd5, 1, 0);
    add("dn4",     1,1,0,0, 8'd0, 8'd5, 0, 8'd4, 0, 0);
    // Down saturate on C.
    add("ldDnS",   1,1,0,1, 8'd1, 8'd5, 2, 8'd1, 0, 0);
    for (int k = 0; k < 3; k++)
      add("dnSat", 1,1,0,0, 8'd0, 8'd5, 2, 8'd0, 0, 1);
    // Up saturate with a loaded value above the limit.
    add("ld250",   1,1,1,1, 8'd250, 8'd200, 2, 8'd250, 0, 1);
    for (int k = 0; k < 3; k++)
      add("upSat", 1,1,1,0, 8'd0, 8'd200, 2, 8'd200, 0, 1);
    // Limit lowered at runtime below the current count.
    add("ld6A",    1,1,1,1, 8'd6, 8'd7, 0, 8'd6, 0, 0);
    add("mvDrop",  1,1,1,0, 8'd0, 8'd3, 0, 8'd0, 1, 0);
    // Reset mid-prescale with load pending.
    add("ld6B",    1,1,1,1, 8'd6, 8'd9, 1, 8'd6, 0, 0);
    add("preR1",   1,1,1,0, 8'd0, 8'd9, 1, 8'd6, 0, 0);
    add("preR2",   1,1,1,0, 8'd0, 8'd9, 1, 8'd6, 0, 0);
    add("rstMid",  0,1,1,1, 8'd3, 8'd9, 1, 8'd0, 0, 0);
    for (int k = 0; k < 3; k++)
      add("preClr",1,1,1,0, 8'd0, 8'd9, 1, 8'd0, 0, 0);
    add("stepR",   1,1,1,0, 8'd0, 8'd9, 1, 8'd1, 0, 0);
    // Load on the prescaler terminal cycle.
    add("ld2B",    1,1,1,1, 8'd2, 8'd9, 1, 8'd2, 0, 0);
    for (int k = 0; k < 3; k++)
      add("preL",  1,1,1,0, 8'd0, 8'd9, 1, 8'd2, 0, 0);
    add("ldTerm",  1,1,1,1, 8'd7, 8'd9, 1, 8'd7, 0, 0);
    for (int k = 0; k < 3; k++)
      add("preL2", 1,1,1,0, 8'd0, 8'd9, 1, 8'd7, 0, 0);
    add("stepL",   1,1,1,0, 8'd0, 8'd9, 1, 8'd8, 0, 0);
    // max_val = 0 with alternating direction.
    add("ldZero",  1,1,1,1, 8'd0, 8'd0, 0, 8'd0, 0, 1);
    add("z_dn",    1,1,0,0, 8'd0, 8'd0, 0, 8'd0, 1, 1);
    add("z_up",    1,1,1,0, 8'd0, 8'd0, 0, 8'd0, 1, 1);
    add("z_dn2",   1,1,0,0, 8'd0, 8'd0, 0, 8'd0, 1, 1);
    add("z_idle",  1,0,0,0, 8'd0, 8'd0, 0, 8'd0, 0, 1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; en = vecs[i].en; up = vecs[i].up;
      load = vecs[i].load; load_val = vecs[i].lv; max_val = vecs[i].mv;
      if (vecs[i].dut == 3) begin
        for (int d = 0; d < 3; d++) begin
          e.name = vecs[i].name; e.dut = d; e.cnt = vecs[i].cnt;
          e.wr = vecs[i].wr; e.al = vecs[i].al;
          exp_q.push_back(e);
        end
      end else begin
        e.name = vecs[i].name; e.dut = vecs[i].dut; e.cnt = vecs[i].cnt;
        e.wr = vecs[i].wr; e.al = vecs[i].al;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_one(e.name, e.dut, e.cnt, e.wr, e.al);
      end
    end

    // at_limit must follow up with no clock in between.
    reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'd0; max_val = 8'd9;
    @(posedge clk); #1;
    load = 1'b0; en = 1'b0;
    up = 1'b0; #1; check_one("alDn0", 2, 8'd0, 1'b0, 1'b1);
    up = 1'b1; #1; check_one("alUp0", 2, 8'd0, 1'b0, 1'b0);
    load = 1'b1; load_val = 8'd9;
    @(posedge clk); #1;
    load = 1'b0;
    up = 1'b1; #1; check_one("alUp9", 2, 8'd9, 1'b0, 1'b1);
    up = 1'b0; #1; check_one("alDn9", 2, 8'd9, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
